hashcore_dispatch: RTL and testbench

Work dispatcher and result arbiter for a bank of `hashcore` instances on one `hash_clk`. It accepts one work unit as 32-bit words and broadcasts it to all cores as a single contiguous serial `din`/`shift` burst. It assigns each core its fixed `nonce_msb` prefix. It captures the one-cycle golden-nonce strobes from every core and serialises them, round-robin, through a small FIFO to the comms interface.

---
 rtl/hashcore_dispatch.sv | 187 ++++++++++++++++++
 tb/tb_hashcore_dispatch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hashcore_dispatch.sv
// hashcore_dispatch: broadcasts one work unit serially to a bank of hashcores
// and round-robin arbitrates their golden-nonce strobes into a small FWFT FIFO.
// Optional build macro: DISCARD_STALE_EN (flush and ignore results of superseded work).
module hashcore_dispatch #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned WORK_BITS  = 352,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    hash_clk,
    input  logic                    reset_n,
    input  logic [31:0]             work_data,
    input  logic                    work_valid,
    output logic                    work_ready,
    output logic                    core_din,
    output logic                    core_shift,
    output logic [3*NUM_CORES-1:0]  core_nonce_msb,
    input  logic [32*NUM_CORES-1:0] core_golden_nonce,
    input  logic [NUM_CORES-1:0]    core_match,
    output logic [31:0]             gn_data,
    output logic                    gn_valid,
    input  logic                    gn_ready,
    output logic                    busy,
    output logic                    overflow
);
    localparam int unsigned NWORDS = WORK_BITS / 32;
    localparam int unsigned WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BCW    = $clog2(WORK_BITS);
    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, SHIFT, GAP} state_t;

    state_t           state, state_nxt;
    logic [WCW-1:0]   word_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic [BCW-1:0]   word_from_end;
    logic [WCW-1:0]   rd_word;
    logic [31:0]      work_mem [NWORDS];
    logic             collecting, accept, last_word, start_shift;

    logic [NUM_CORES-1:0] pend, cap, grant_vec, grant_clr;
    logic [31:0]          pend_nonce [NUM_CORES];
    logic [2:0]           rr_ptr, rr_nxt;
    logic                 grant_any, can_push, push, pop, flush;
    logic [31:0]          grant_nonce;

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [31:0]  fifo_mem [FIFO_DEPTH];
    logic         fifo_empty, fifo_full;

    assign collecting  = (state == IDLE) || (state == COLLECT);
    assign work_ready  = reset_n && collecting;
    assign accept      = work_valid && work_ready;
    assign last_word   = (word_cnt == WCW'(NWORDS - 1));
    assign start_shift = accept && last_word;
    assign busy        = (state != IDLE);

`ifdef DISCARD_STALE_EN
    assign flush = start_shift;
    assign cap   = core_match & {NUM_CORES{!((state == SHIFT) || (state == GAP))}};
`else
    assign flush = 1'b0;
    assign cap   = core_match;
`endif

    // FSM state register
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state and serial broadcast outputs; bit_cnt counts down, so the
    // word selected is counted from the end of the work unit
    always_comb begin
        state_nxt     = state;
        core_shift    = 1'b0;
        core_din      = 1'b0;
        word_from_end = bit_cnt >> 5;
        rd_word       = WCW'(NWORDS - 1) - WCW'(word_from_end);
        case (state)
            IDLE:    if (accept) state_nxt = last_word ? SHIFT : COLLECT;
            COLLECT: if (start_shift) state_nxt = SHIFT;
            SHIFT: begin
                core_shift = 1'b1;
                core_din   = work_mem[rd_word][bit_cnt[4:0]];
                if (bit_cnt == '0) state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // word index and shift bit counters
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (accept) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            if (start_shift)                          bit_cnt <= BCW'(WORK_BITS - 1);
            else if (state == SHIFT && bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // work word storage
    always_ff @(posedge hash_clk) begin
        if (accept) work_mem[word_cnt] <= work_data;
    end

    // fixed nonce prefix per core
    always_comb begin
        core_nonce_msb = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) core_nonce_msb[3*i +: 3] = 3'(i);
    end

    // round-robin pick of the first pending core at or after rr_ptr
    always_comb begin
        grant_any   = 1'b0;
        grant_vec   = '0;
        grant_nonce = '0;
        rr_nxt      = rr_ptr;
        for (int unsigned off = 0; off < NUM_CORES; off++) begin
            for (int unsigned j = 0; j < NUM_CORES; j++) begin
                if (!grant_any && pend[j] && (j == (32'(rr_ptr) + off) % NUM_CORES)) begin
                    grant_any    = 1'b1;
                    grant_vec[j] = 1'b1;
                    grant_nonce  = pend_nonce[j];
                    rr_nxt       = 3'((j + 1) % NUM_CORES);
                end
            end
        end
        push      = grant_any && can_push && !flush;
        grant_clr = grant_vec & {NUM_CORES{push}};
    end

    // pending flags, round-robin pointer and sticky overflow
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (cap[i]) begin
                    pend[i] <= 1'b1;
                    if (pend[i] && !grant_clr[i]) overflow <= 1'b1;
                end else if (grant_clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (push) rr_ptr <= rr_nxt;
        end
    end

    // latest nonce per core
    always_ff @(posedge hash_clk) begin
        for (int unsigned i = 0; i < NUM_CORES; i++)
            if (cap[i]) pend_nonce[i] <= core_golden_nonce[32*i +: 32];
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign gn_valid   = !fifo_empty;
    assign gn_data    = gn_valid ? fifo_mem[rd_ptr[AW-1:0]] : '0;
    assign pop        = gn_valid && gn_ready;
    assign can_push   = !fifo_full || pop;

    // FIFO pointers; a pop frees the slot for a same-cycle push when full
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge hash_clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= grant_nonce;
    end
endmodule

// File: tb/tb_hashcore_dispatch.sv
// Directed bench for hashcore_dispatch: arbiter cycle table plus dispatch,
// reset and stale-result sequences.
module tb_hashcore_dispatch;
    localparam int unsigned NC = 4;
    localparam int unsigned WB = 352;
    localparam int unsigned FD = 4;
    localparam int unsigned NW = WB / 32;

    logic             hash_clk;
    logic             reset_n;
    logic [31:0]      work_data;
    logic             work_valid;
    logic             work_ready;
    logic             core_din;
    logic             core_shift;
    logic [3*NC-1:0]  core_nonce_msb;
    logic [32*NC-1:0] core_golden_nonce;
    logic [NC-1:0]    core_match;
    logic [31:0]      gn_data;
    logic             gn_valid;
    logic             gn_ready;
    logic             busy;
    logic             overflow;

    int tests = 0;
    int fails = 0;

    hashcore_dispatch #(.NUM_CORES(NC), .WORK_BITS(WB), .FIFO_DEPTH(FD)) dut (
        .hash_clk(hash_clk), .reset_n(reset_n),
        .work_data(work_data), .work_valid(work_valid), .work_ready(work_ready),
        .core_din(core_din), .core_shift(core_shift), .core_nonce_msb(core_nonce_msb),
        .core_golden_nonce(core_golden_nonce), .core_match(core_match),
        .gn_data(gn_data), .gn_valid(gn_valid), .gn_ready(gn_ready),
        .busy(busy), .overflow(overflow)
    );

    initial begin
        hash_clk = 1'b0;
        forever #5 hash_clk = ~hash_clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic          ready;
        logic [3:0]    match;
        logic [127:0]  nonces;
        logic          exp_valid;
        logic [31:0]   exp_data;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [22];
    logic [WB-1:0] exp_stream;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic load_work(input bit toggle, output int accepted);
        int cyc;
        cyc = 0;
        accepted = 0;
        while (accepted < int'(NW) && cyc < 200) begin
            work_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            work_data  = 32'h100 + 32'(accepted);
            #1;
            if (work_valid && work_ready) accepted++;
            @(posedge hash_clk);
            #1;
            cyc++;
        end
        work_valid = 1'b0;
    endtask

    task automatic observe_shift(input string tag);
        logic [WB-1:0] got;
        int n;
        int wr_bad;
        got = '0;
        n = 0;
        wr_bad = 0;
        check({tag, "_shift_start"}, 32'(core_shift), 32'd1);
        for (int c = 0; c < int'(WB) + 20; c++) begin
            if (!core_shift) break;
            got = {got[WB-2:0], core_din};
            n++;
            if (work_ready) wr_bad++;
            tick();
        end
        check({tag, "_shift_len"}, 32'(n), 32'(WB));
        check({tag, "_first_word"}, got[WB-1 -: 32], 32'h0000_0100);
        check({tag, "_last_word"}, got[31:0], 32'h0000_010A);
        tests++;
        if (got !== exp_stream) begin
            fails++;
            $display("FAIL %s_stream: got %h expected %h", tag, got, exp_stream);
        end
        check({tag, "_ready_in_shift"}, 32'(wr_bad), 32'd0);
        check({tag, "_gap_shift"}, 32'(core_shift), 32'd0);
        check({tag, "_gap_busy"}, 32'(busy), 32'd1);
        check({tag, "_gap_ready"}, 32'(work_ready), 32'd0);
        tick();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(work_ready), 32'd1);
    endtask

    initial begin
        int acc;
        int wait_cyc;

        // ready, match, nonces {c3,c2,c1,c0}, exp_valid, exp_data, exp_overflow
        vecs[0]  = '{1'b1, 4'b1101, {32'h6000_3333, 32'h4000_2222, 32'h0, 32'h0000_1111}, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 128'h0, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h0000_1111, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h4000_2222, 1'b0};
        vecs[4]  = '{1'b1, 4'b0101, {32'h0, 32'h4000_BBBB, 32'h0, 32'h0000_AAAA}, 1'b1, 32'h6000_3333, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 128'h0, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h0000_AAAA, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h4000_BBBB, 1'b0};
        vecs[8]  = '{1'b0, 4'b0001, {96'h0, 32'h1000_0000}, 1'b0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0010, {64'h0, 32'h1000_0001, 32'h0}, 1'b0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 4'b0100, {32'h0, 32'h1000_0002, 64'h0}, 1'b1, 32'h1000_0000, 1'b0};
        vecs[11] = '{1'b0, 4'b1000, {32'h1000_0003, 96'h0}, 1'b1, 32'h1000_0000, 1'b0};
        vecs[12] = '{1'b0, 4'b0001, {96'h0, 32'h1000_0004}, 1'b1, 32'h1000_0000, 1'b0};
        vecs[13] = '{1'b0, 4'b0010, {64'h0, 32'h1000_0005, 32'h0}, 1'b1, 32'h1000_0000, 1'b0};
        vecs[14] = '{1'b0, 4'b0001, {96'h0, 32'h1000_0006}, 1'b1, 32'h1000_0000, 1'b0};
        vecs[15] = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h1000_0000, 1'b1};
        vecs[16] = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h1000_0001, 1'b1};
        vecs[17] = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h1000_0002, 1'b1};
        vecs[18] = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h1000_0003, 1'b1};
        vecs[19] = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h1000_0006, 1'b1};
        vecs[20] = '{1'b1, 4'b0000, 128'h0, 1'b1, 32'h1000_0005, 1'b1};
        vecs[21] = '{1'b1, 4'b0000, 128'h0, 1'b0, 32'h0, 1'b1};

        exp_stream = '0;
        for (int k = 0; k < int'(NW); k++) exp_stream = {exp_stream[WB-33:0], 32'h100 + 32'(k)};

        reset_n = 1'b0;
        work_valid = 1'b0;
        work_data = '0;
        core_match = '0;
        core_golden_nonce = '0;
        gn_ready = 1'b0;

        // reset state
        #2;
        check("rst_work_ready", 32'(work_ready), 32'd0);
        check("rst_core_shift", 32'(core_shift), 32'd0);
        check("rst_core_din", 32'(core_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gn_valid", 32'(gn_valid), 32'd0);
        check("rst_gn_data", gn_data, 32'h0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("nonce_msb", 32'(core_nonce_msb), 32'h688);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("post_rst_work_ready", 32'(work_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        tick();

        // arbiter / FIFO cycle table
        for (int i = 0; i < 22; i++) begin
            gn_ready = vecs[i].ready;
            core_match = vecs[i].match;
            core_golden_nonce = vecs[i].nonces;
            #1;
            check($sformatf("vec%0d_valid", i), 32'(gn_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), gn_data, vecs[i].exp_data);
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            @(posedge hash_clk);
            #1;
        end
        core_match = '0;
        core_golden_nonce = '0;

        // reset in the middle of a shift burst, with a result queued
        gn_ready = 1'b0;
        core_golden_nonce[63:32] = 32'h7777_0001;
        core_match = 4'b0010;
        tick();
        core_match = '0;
        tick();
        tick();
        check("mid_rst_queued", 32'(gn_valid), 32'd1);
        load_work(1'b0, acc);
        check("mid_rst_accepted", 32'(acc), 32'(NW));
        repeat (100) tick();
        check("mid_rst_shift_before", 32'(core_shift), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_shift_async", 32'(core_shift), 32'd0);
        check("mid_rst_busy_async", 32'(busy), 32'd0);
        check("mid_rst_ready_low", 32'(work_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check("mid_rst_ready", 32'(work_ready), 32'd1);
        check("mid_rst_fifo_empty", 32'(gn_valid), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        tick();
        check("mid_rst_idle_shift", 32'(core_shift), 32'd0);

        // dispatch with work_valid held high
        load_work(1'b0, acc);
        check("held_accepted", 32'(acc), 32'(NW));
        observe_shift("held");

        // dispatch with work_valid toggling
        load_work(1'b1, acc);
        check("toggle_accepted", 32'(acc), 32'(NW));
        observe_shift("toggle");

        // match arriving during the shift burst
        gn_ready = 1'b1;
        load_work(1'b0, acc);
        repeat (5) tick();
        core_golden_nonce[63:32] = 32'h5555_0001;
        core_match = 4'b0010;
        tick();
        core_match = '0;
        check("shift_match_c1", 32'(gn_valid), 32'd0);
        tick();
`ifdef DISCARD_STALE_EN
        check("shift_match_c2_valid", 32'(gn_valid), 32'd0);
`else
        check("shift_match_c2_valid", 32'(gn_valid), 32'd1);
        check("shift_match_c2_data", gn_data, 32'h5555_0001);
`endif
        tick();
        check("shift_match_c3", 32'(gn_valid), 32'd0);
        wait_cyc = 0;
        while (busy && wait_cyc < 500) begin
            tick();
            wait_cyc++;
        end
        check("shift_match_busy_end", 32'(busy), 32'd0);
        check("final_overflow", 32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
